// File: rtl/irig_pkg.sv
// Shared IRIG-B definitions for the encoder, the bit mapper and decoder-side benches.
// Holds symbol encodings, symbol high times, frame geometry, marker positions
// and the packed timestamp that forms the frame and holding registers.
package irig_pkg;

  // Symbol encodings as driven on the sym output
  localparam logic [1:0] SYM_D0   = 2'd0;
  localparam logic [1:0] SYM_D1   = 2'd1;
  localparam logic [1:0] SYM_MARK = 2'd2;

  // High time per symbol and position length, in milliseconds
  localparam int unsigned HI_D0_MS   = 2;
  localparam int unsigned HI_D1_MS   = 5;
  localparam int unsigned HI_MARK_MS = 8;
  localparam int unsigned BIT_MS     = 10;

  localparam int unsigned FRAME_BITS = 100;

  // Marker positions: 0 and every position ending in 9
  localparam logic [FRAME_BITS-1:0] MARKER_MASK =
      (100'd1 << 0)  | (100'd1 << 9)  | (100'd1 << 19) | (100'd1 << 29) |
      (100'd1 << 39) | (100'd1 << 49) | (100'd1 << 59) | (100'd1 << 69) |
      (100'd1 << 79) | (100'd1 << 89) | (100'd1 << 99);

  // Timestamp as carried by the holding and frame registers (BCD except sbs)
  typedef struct packed {
    logic [6:0]  sec;
    logic [6:0]  min;
    logic [5:0]  hour;
    logic [9:0]  day;
    logic [7:0]  year;
    logic [16:0] sbs;
  } ts_t;

  // High time in ms for a symbol
  function automatic logic [3:0] hi_ms(logic [1:0] s);
    case (s)
      SYM_D1:   return 4'(HI_D1_MS);
      SYM_MARK: return 4'(HI_MARK_MS);
      default:  return 4'(HI_D0_MS);
    endcase
  endfunction

endpackage

// File: rtl/irig_encoder_if.sv
// Timestamp load channel of the IRIG encoder: one-deep valid/ready offer of a
// full timestamp. master = timestamp source, slave = encoder.
interface irig_encoder_if;
  logic        ts_valid;
  logic        ts_ready;
  logic [6:0]  ts_sec;
  logic [6:0]  ts_min;
  logic [5:0]  ts_hour;
  logic [9:0]  ts_day;
  logic [7:0]  ts_year;
  logic [16:0] ts_sbs;

  modport master (
    output ts_valid, ts_sec, ts_min, ts_hour, ts_day, ts_year, ts_sbs,
    input  ts_ready
  );

  modport slave (
    input  ts_valid, ts_sec, ts_min, ts_hour, ts_day, ts_year, ts_sbs,
    output ts_ready
  );
endinterface

// File: rtl/irig_bit_map.sv
// Combinational IRIG-B frame bit map: frame position + timestamp -> symbol.
// Ports:
//   bit_idx  in  frame position 0..99 (out-of-range positions give d0)
//   frame    in  timestamp being transmitted
//   sym      out symbol code (SYM_D0 / SYM_D1 / SYM_MARK)
module irig_bit_map
  import irig_pkg::*;
(
  input  logic [6:0] bit_idx,
  input  ts_t        frame,
  output logic [1:0] sym
);

  // Field bits laid out by frame position, LSB first; unlisted positions stay 0
  logic [FRAME_BITS-1:0] field_bits;

  always_comb begin
    field_bits        = '0;
    field_bits[4:1]   = frame.sec[3:0];
    field_bits[8:6]   = frame.sec[6:4];
    field_bits[13:10] = frame.min[3:0];
    field_bits[17:15] = frame.min[6:4];
    field_bits[23:20] = frame.hour[3:0];
    field_bits[26:25] = frame.hour[5:4];
    field_bits[33:30] = frame.day[3:0];
    field_bits[38:35] = frame.day[7:4];
    field_bits[41:40] = frame.day[9:8];
    field_bits[53:50] = frame.year[3:0];
    field_bits[58:55] = frame.year[7:4];
    field_bits[88:80] = frame.sbs[8:0];
    field_bits[97:90] = frame.sbs[16:9];
  end

  always_comb begin
    sym = SYM_D0;
    if (bit_idx < 7'(FRAME_BITS)) begin
      if (MARKER_MASK[bit_idx]) begin
        sym = SYM_MARK;
      end else if (field_bits[bit_idx]) begin
        sym = SYM_D1;
      end
    end
  end

endmodule

// File: rtl/irig_encoder.sv
// IRIG-B (DC level-shift) frame transmitter. Each accepted pps starts a
// 100-position, 1 s frame carrying the timestamp taken from a one-deep
// holding register loaded over a valid/ready channel.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   enable        transmitter enable; low forces idle next cycle
//   pps           one-cycle on-time pulse, starts (or restarts) a frame
//   ts            timestamp load channel (slave side)
//   irig_out      IRIG-B level output
//   frame_active  frame in progress
//   bit_idx, sym  current frame position and its symbol
//   ts_stale      pulse: frame started without a fresh timestamp
//   sync_err      pulse: pps arrived while a frame was in progress
module irig_encoder
  import irig_pkg::*;
#(
  parameter int unsigned CLK_HZ = 10_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         pps,
  irig_encoder_if.slave ts,
  output logic         irig_out,
  output logic         frame_active,
  output logic [6:0]   bit_idx,
  output logic [1:0]   sym,
  output logic         ts_stale,
  output logic         sync_err
);

  localparam int unsigned MS_DIV = CLK_HZ / 1000;
  localparam int unsigned MsW    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [MsW-1:0] MsLast = MsW'(MS_DIV - 1);

  typedef enum logic [0:0] {StIdle, StTx} state_e;

  state_e         state_q, state_d;
  logic [MsW-1:0] ms_cnt_q, ms_cnt_d;
  logic [3:0]     ms_in_bit_q, ms_in_bit_d;
  logic [6:0]     bit_idx_q, bit_idx_d;
  logic [1:0]     sym_q, sym_d;
  logic           irig_out_q, irig_out_d;
  logic           stale_q, stale_d;
  logic           sync_err_q, sync_err_d;
  logic           full_q, full_d;
  ts_t            hold_q, hold_d;
  ts_t            frame_q, frame_d;

  ts_t        ts_in;
  logic       load;
  logic [1:0] map_sym;

  assign ts_in.sec  = ts.ts_sec;
  assign ts_in.min  = ts.ts_min;
  assign ts_in.hour = ts.ts_hour;
  assign ts_in.day  = ts.ts_day;
  assign ts_in.year = ts.ts_year;
  assign ts_in.sbs  = ts.ts_sbs;

  assign load = ts.ts_valid && !full_q;

  always_comb begin
    state_d     = state_q;
    ms_cnt_d    = ms_cnt_q;
    ms_in_bit_d = ms_in_bit_q;
    bit_idx_d   = bit_idx_q;
    stale_d     = 1'b0;
    sync_err_d  = 1'b0;
    full_d      = full_q;
    hold_d      = hold_q;
    frame_d     = frame_q;

    if (load) begin
      hold_d = ts_in;
      full_d = 1'b1;
    end

    if (!enable) begin
      state_d     = StIdle;
      ms_cnt_d    = '0;
      ms_in_bit_d = '0;
      bit_idx_d   = '0;
    end else if (pps) begin
      sync_err_d  = (state_q == StTx);
      state_d     = StTx;
      ms_cnt_d    = '0;
      ms_in_bit_d = '0;
      bit_idx_d   = '0;
      if (full_q) begin
        frame_d = hold_q;
        full_d  = 1'b0;
      end else if (load) begin
        // Same-cycle load bypasses the holding register
        frame_d = ts_in;
        full_d  = 1'b0;
      end else begin
        stale_d = 1'b1;
      end
    end else if (state_q == StTx) begin
      if (ms_cnt_q == MsLast) begin
        ms_cnt_d = '0;
        if (ms_in_bit_q == 4'(BIT_MS - 1)) begin
          ms_in_bit_d = '0;
          if (bit_idx_q == 7'(FRAME_BITS - 1)) begin
            state_d   = StIdle;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 7'd1;
          end
        end else begin
          ms_in_bit_d = ms_in_bit_q + 4'd1;
        end
      end else begin
        ms_cnt_d = ms_cnt_q + MsW'(1);
      end
    end
  end

  // Outputs are computed from next state so they register in step with it
  irig_bit_map u_bit_map (
    .bit_idx (bit_idx_d),
    .frame   (frame_d),
    .sym     (map_sym)
  );

  assign sym_d      = (state_d == StTx) ? map_sym : SYM_D0;
  assign irig_out_d = (state_d == StTx) && (ms_in_bit_d < hi_ms(map_sym));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ms_cnt_q    <= '0;
      ms_in_bit_q <= '0;
      bit_idx_q   <= '0;
      sym_q       <= SYM_D0;
      irig_out_q  <= 1'b0;
      stale_q     <= 1'b0;
      sync_err_q  <= 1'b0;
      full_q      <= 1'b0;
      hold_q      <= '0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      ms_in_bit_q <= ms_in_bit_d;
      bit_idx_q   <= bit_idx_d;
      sym_q       <= sym_d;
      irig_out_q  <= irig_out_d;
      stale_q     <= stale_d;
      sync_err_q  <= sync_err_d;
      full_q      <= full_d;
      hold_q      <= hold_d;
      frame_q     <= frame_d;
    end
  end

  assign ts.ts_ready   = !full_q;
  assign irig_out      = irig_out_q;
  assign frame_active  = (state_q == StTx);
  assign bit_idx       = bit_idx_q;
  assign sym           = sym_q;
  assign ts_stale      = stale_q;
  assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_irig_encoder.sv
// Self-checking bench for irig_encoder at CLK_HZ = 10000 (10 clocks per ms).
// Expected symbols come from decimal time values via digit arithmetic.
module tb_irig_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pps;
  logic       irig_out;
  logic       frame_active;
  logic [6:0] bit_idx;
  logic [1:0] sym;
  logic       ts_stale;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  irig_encoder_if tsif ();

  irig_encoder #(
    .CLK_HZ (10000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .pps          (pps),
    .ts           (tsif),
    .irig_out     (irig_out),
    .frame_active (frame_active),
    .bit_idx      (bit_idx),
    .sym          (sym),
    .ts_stale     (ts_stale),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bcd(input int v);
    return 32'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Reference symbol for a position: 2 = mark, 1 = d1, 0 = d0
  function automatic int ref_sym(input int p, input int h, input int m, input int s,
                                 input int d, input int y);
    int sbs;
    int val;
    int base;
    sbs = h * 3600 + m * 60 + s;
    if (p == 0 || p % 10 == 9) return 2;
    val  = 0;
    base = p;
    if (p >= 1 && p <= 4)        begin val = s % 10;         base = 1;  end
    else if (p >= 6 && p <= 8)   begin val = s / 10;         base = 6;  end
    else if (p >= 10 && p <= 13) begin val = m % 10;         base = 10; end
    else if (p >= 15 && p <= 17) begin val = m / 10;         base = 15; end
    else if (p >= 20 && p <= 23) begin val = h % 10;         base = 20; end
    else if (p >= 25 && p <= 26) begin val = h / 10;         base = 25; end
    else if (p >= 30 && p <= 33) begin val = d % 10;         base = 30; end
    else if (p >= 35 && p <= 38) begin val = (d / 10) % 10;  base = 35; end
    else if (p >= 40 && p <= 41) begin val = d / 100;        base = 40; end
    else if (p >= 50 && p <= 53) begin val = y % 10;         base = 50; end
    else if (p >= 55 && p <= 58) begin val = y / 10;         base = 55; end
    else if (p >= 80 && p <= 88) begin val = sbs;            base = 80; end
    else if (p >= 90 && p <= 97) begin val = sbs >> 9;       base = 90; end
    return (val >> (p - base)) & 1;
  endfunction

  task automatic drive_ts(input int h, input int m, input int s, input int d, input int y);
    tsif.ts_sec  = 7'(bcd(s));
    tsif.ts_min  = 7'(bcd(m));
    tsif.ts_hour = 6'(bcd(h));
    tsif.ts_day  = 10'(bcd(d));
    tsif.ts_year = 8'(bcd(y));
    tsif.ts_sbs  = 17'(h * 3600 + m * 60 + s);
  endtask

  task automatic load_ts(input int h, input int m, input int s, input int d, input int y);
    drive_ts(h, m, s, d, y);
    tsif.ts_valid = 1'b1;
    tick();
    tsif.ts_valid = 1'b0;
  endtask

  task automatic pulse_pps();
    pps = 1'b1;
    tick();
    pps = 1'b0;
  endtask

  task automatic abort_frame();
    enable = 1'b0;
    tick();
    check("abort_active", frame_active, 0);
    enable = 1'b1;
  endtask

  // Checks npos positions starting at the first clock of position 0
  task automatic check_frame(input int h, input int m, input int s, input int d, input int y,
                             input int npos);
    int es;
    int exp_hi;
    int lead;
    int tot;
    bit low_seen;
    for (int p = 0; p < npos; p++) begin
      es       = ref_sym(p, h, m, s, d, y);
      exp_hi   = (es == 2) ? 80 : (es == 1) ? 50 : 20;
      lead     = 0;
      tot      = 0;
      low_seen = 1'b0;
      check($sformatf("bit_idx@%0d", p), bit_idx, p);
      check($sformatf("sym@%0d", p), sym, es);
      for (int c = 0; c < 100; c++) begin
        if (irig_out === 1'b1) begin
          tot++;
          if (!low_seen) lead++;
        end else begin
          low_seen = 1'b1;
        end
        tick();
      end
      check($sformatf("hi_lead@%0d", p), lead, exp_hi);
      check($sformatf("hi_tot@%0d", p), tot, exp_hi);
    end
    if (npos == 100) begin
      check("end_active", frame_active, 0);
      check("end_out", irig_out, 0);
    end
  endtask

  int h, m, s, d, y;
  int h2, m2, s2, d2, y2;

  task automatic rand_ts(output int rh, output int rm, output int rs, output int rd,
                         output int ry);
    rh = int'($urandom_range(23));
    rm = int'($urandom_range(59));
    rs = int'($urandom_range(59));
    rd = int'($urandom_range(366, 1));
    ry = int'($urandom_range(99));
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    pps = 1'b0;
    tsif.ts_valid = 1'b0;
    drive_ts(0, 0, 0, 0, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_out", irig_out, 0);
    check("rst_active", frame_active, 0);
    check("rst_bit_idx", bit_idx, 0);
    check("rst_sym", sym, 0);
    check("rst_ready", tsif.ts_ready, 1);
    check("rst_stale", ts_stale, 0);
    check("rst_sync", sync_err, 0);

    // Directed frame 12:34:56, day 123, year 24
    load_ts(12, 34, 56, 123, 24);
    check("load_ready", tsif.ts_ready, 0);
    check("sbs_value", tsif.ts_sbs, 45296);
    pulse_pps();
    check("start_out", irig_out, 1);
    check("start_active", frame_active, 1);
    check("start_stale", ts_stale, 0);
    check("start_ready", tsif.ts_ready, 1);
    check_frame(12, 34, 56, 123, 24, 100);

    // pps without a fresh load repeats the previous frame
    pulse_pps();
    check("stale_pulse", ts_stale, 1);
    check("stale_sync", sync_err, 0);
    check_frame(12, 34, 56, 123, 24, 60);
    abort_frame();

    // Random full frames
    for (int i = 0; i < 2; i++) begin
      rand_ts(h, m, s, d, y);
      load_ts(h, m, s, d, y);
      pulse_pps();
      check("rnd_stale", ts_stale, 0);
      check_frame(h, m, s, d, y, 100);
    end

    // Load and pps in the same cycle with the register empty
    rand_ts(h, m, s, d, y);
    drive_ts(h, m, s, d, y);
    tsif.ts_valid = 1'b1;
    pps = 1'b1;
    tick();
    tsif.ts_valid = 1'b0;
    pps = 1'b0;
    check("bypass_ready", tsif.ts_ready, 1);
    check("bypass_stale", ts_stale, 0);
    check_frame(h, m, s, d, y, 45);
    abort_frame();

    // Offer held while full: first value goes out, second loads afterwards
    rand_ts(h, m, s, d, y);
    rand_ts(h2, m2, s2, d2, y2);
    drive_ts(h, m, s, d, y);
    tsif.ts_valid = 1'b1;
    tick();
    check("full_ready", tsif.ts_ready, 0);
    drive_ts(h2, m2, s2, d2, y2);
    tick();
    check("held_ready", tsif.ts_ready, 0);
    pulse_pps();
    check("held_start_ready", tsif.ts_ready, 1);
    check_frame(h, m, s, d, y, 30);
    check("second_load_ready", tsif.ts_ready, 0);
    tsif.ts_valid = 1'b0;
    abort_frame();
    pulse_pps();
    check("second_stale", ts_stale, 0);
    check_frame(h2, m2, s2, d2, y2, 40);

    // pps at bit 40 restarts the frame
    pulse_pps();
    check("sync_pulse", sync_err, 1);
    check("sync_out", irig_out, 1);
    check("sync_bit_idx", bit_idx, 0);
    check("sync_sym", sym, 2);
    check("sync_stale", ts_stale, 1);
    check_frame(h2, m2, s2, d2, y2, 55);

    // enable drop mid-high at bit 55
    repeat (10) tick();
    check("en_pre_out", irig_out, 1);
    check("en_pre_idx", bit_idx, 55);
    enable = 1'b0;
    tick();
    check("en_out", irig_out, 0);
    check("en_active", frame_active, 0);
    pulse_pps();
    check("en_pps_active", frame_active, 0);
    check("en_pps_out", irig_out, 0);
    check("en_pps_stale", ts_stale, 0);
    check("en_pps_sync", sync_err, 0);
    enable = 1'b1;
    tick();

    // Reset mid-high at bit 55 clears frame and holding registers
    rand_ts(h, m, s, d, y);
    load_ts(h, m, s, d, y);
    pulse_pps();
    check_frame(h, m, s, d, y, 55);
    repeat (10) tick();
    load_ts(1, 2, 3, 4, 5);
    check("rst_pre_ready", tsif.ts_ready, 0);
    check("rst_pre_out", irig_out, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out", irig_out, 0);
    check("mrst_active", frame_active, 0);
    check("mrst_ready", tsif.ts_ready, 1);
    check("mrst_bit_idx", bit_idx, 0);
    pulse_pps();
    check("mrst_stale", ts_stale, 1);
    check_frame(0, 0, 0, 0, 0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irig_encoder.md
# irig_encoder

IRIG-B (DC level-shift, pulse-width coded) frame transmitter. It is the transmit counterpart of the team's IRIG decoder. On each PPS it emits one 100-bit, 1-second frame that encodes a timestamp. The timestamp is pre-loaded through a one-deep valid/ready holding register. It drives the IRIG output pin and provides loopback stimulus for the decoder.

## Interface
- CLK_HZ, 10_000_000, clock frequency in Hz. Must be a multiple of 1000 and at least 2000. MS_DIV = CLK_HZ/1000 clocks per millisecond.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- enable  in  1  transmitter enable
- pps  in  1  one-cycle on-time pulse; starts a frame
- ts_valid  in  1  timestamp offer
- ts_ready  out  1  holding register empty
- ts_sec  in  7  BCD seconds {tens[2:0], units[3:0]}
- ts_min  in  7  BCD minutes {tens[2:0], units[3:0]}
- ts_hour  in  6  BCD hours {tens[1:0], units[3:0]}
- ts_day  in  10  BCD day-of-year {hund[1:0], tens[3:0], units[3:0]}
- ts_year  in  8  BCD year {tens[3:0], units[3:0]}
- ts_sbs  in  17  binary straight seconds of day
- irig_out  out  1  IRIG-B level output
- frame_active  out  1  frame in progress
- bit_idx  out  7  current frame position, 0..99
- sym  out  2  current symbol: 0 = d0, 1 = d1, 2 = mark
- ts_stale  out  1  one-cycle pulse: frame started with no new timestamp
- sync_err  out  1  one-cycle pulse: pps arrived mid-frame

## Operation
- **Handshake.** The load fires when ts_valid && ts_ready. It copies all ts_* fields into the holding register and sets the register full. ts_ready = !full.
- **Frame start.** pps is accepted only when enable = 1. On an accepted pps:
  - the holding register is copied into the frame register and full is cleared;
  - if the register was empty, the previous frame register is kept and ts_stale pulses;
  - if a load fires in the same cycle as pps with the register empty, the loaded value goes straight into the frame register and full stays 0.
- **States.**
  - IDLE: irig_out = 0. Accepted pps → TX with bit_idx = 0.
  - TX: after bit 99 completes → IDLE, frame_active = 0.
  - Accepted pps while in TX → restart at bit 0 with the new frame register and pulse sync_err.
  - enable = 0 forces IDLE on the next cycle.
- **Symbol timing.** Each position lasts 10 ms (10·MS_DIV clocks). It is high for 2 ms (d0), 5 ms (d1) or 8 ms (mark), then low for the remainder.
- **Frame bit map.** Fields are LSB first. Unlisted positions are d0.
  - Markers (mark): 0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99.
  - Seconds: units 1-4, tens 6-8.
  - Minutes: units 10-13, tens 15-17.
  - Hours: units 20-23, tens 25-26.
  - Day: units 30-33, tens 35-38, hundreds 40-41.
  - Year: units 50-53, tens 55-58.
  - Control bits 60-78: always 0.
  - SBS: bits[8:0] at 80-88, bits[16:9] at 90-97.
  - A field bit of 1 is sent as d1.
- **Counters.**
  - ms_cnt runs 0..MS_DIV-1.
  - ms_in_bit runs 0..9; irig_out = (ms_in_bit < H), where H = 2, 5 or 8.
  - bit_idx runs 0..99 and has no wrap; after 99 the block goes to IDLE.

## Timing
- Latency: pps sampled at cycle t → irig_out = 1 and frame_active = 1 at t+1. The rising edge is the on-time point.
- All outputs are registered.
- ts_stale and sync_err appear at t+1.
- Frame length: exactly 1000·MS_DIV clocks from the first rising edge to the return to IDLE.
- sym and bit_idx update in the same cycle as each new position's rising edge.
- Reset values:
  - irig_out, frame_active, ts_stale, sync_err = 0;
  - bit_idx = 0, sym = 0;
  - ts_ready = 1;
  - frame and holding registers cleared to 0.
- Reset or enable drop mid-frame: irig_out = 0 on the next cycle, no partial symbol completion, holding register kept (cleared by reset only).

## Structure
- Shared package irig_pkg holds:
  - sym encodings SYM_D0/SYM_D1/SYM_MARK;
  - high times HI_D0_MS = 2, HI_D1_MS = 5, HI_MARK_MS = 8, BIT_MS = 10;
  - FRAME_BITS = 100;
  - the marker-position constants.
- Sub-module irig_bit_map is combinational: (bit_idx, frame register) → sym. It is reusable by the decoder's test bench.

## Test plan
- CLK_HZ = 10000 (MS_DIV = 10). Load 12:34:56, day 123, year 24, SBS 45296, then pps → bits 1-8 give d0,d1,d1,d0,d0,d1,d0,d1. Bits 30-41 encode 3, 2, 1. Bits 80-97 encode 45296 (0x0B0F0). Markers are 80 clocks high.
- Symbol widths on the same frame: d0 high 20 clocks, d1 50, mark 80, every position 100 clocks. Frame ends after 10000 clocks.
- pps with no load → ts_stale pulse at t+1, and the frame repeats the previous timestamp.
- Second pps at bit 40 → sync_err pulse, irig_out restarts a mark at t+1, bit_idx = 0.
- Load and pps in the same cycle with the register empty → the new time is transmitted and ts_ready stays 1. Load while full → ts_ready = 0 and the offer is held.
- rst, or enable = 0, at bit 55 mid-high → irig_out = 0 next cycle, frame_active = 0, pps ignored while enable = 0.
